cache_stats_controller: RTL and testbench

Event-counting and end-of-trace sequencer for the cache simulator's usage statistics. Accepts per-access hit/miss events from the data-cache and instruction-cache controllers, keeps the nine statistics counters, and on trace end drains its input pipeline before raising a registered `done`. Its counter outputs and `done` connect directly to the statistics report block, which prints on `done`'s rising edge, so every counter must already hold its final value when `done` rises.

---
 rtl/cache_stats_if.sv | 20 ++
 rtl/cache_stats_controller.sv | 61 ++++++
 tb/tb_cache_stats_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cache_stats_if.sv
// cache_stats_if: event inputs and statistics outputs of the cache statistics controller
interface cache_stats_if #(parameter int CNT_W = 32);
  logic clear, trace_end;
  logic dc_ev_valid, dc_ev_write, dc_ev_hit;
  logic ic_ev_valid, ic_ev_hit;
  logic [CNT_W-1:0] dc_reads, dc_read_hit, dc_read_miss;
  logic [CNT_W-1:0] dc_writes, dc_write_hit, dc_write_miss;
  logic [CNT_W-1:0] ic_reads, ic_read_hit, ic_read_miss;
  logic done, late_event, overflow;
  modport master (
    output clear, trace_end, dc_ev_valid, dc_ev_write, dc_ev_hit, ic_ev_valid, ic_ev_hit,
    input  dc_reads, dc_read_hit, dc_read_miss, dc_writes, dc_write_hit, dc_write_miss,
    input  ic_reads, ic_read_hit, ic_read_miss, done, late_event, overflow
  );
  modport slave (
    input  clear, trace_end, dc_ev_valid, dc_ev_write, dc_ev_hit, ic_ev_valid, ic_ev_hit,
    output dc_reads, dc_read_hit, dc_read_miss, dc_writes, dc_write_hit, dc_write_miss,
    output ic_reads, ic_read_hit, ic_read_miss, done, late_event, overflow
  );
endinterface

// File: rtl/cache_stats_controller.sv
// cache_stats_controller: saturating DC/IC hit/miss counters behind a one-entry stage,
// with a COUNT -> DRAIN -> DONE sequencer so counters are final when done rises.
module cache_stats_controller #(parameter int CNT_W = 32) (
  input logic clk,
  input logic rst,
  cache_stats_if.slave bus
);
  typedef enum logic [1:0] {COUNT, DRAIN, DONE} state_t;
  state_t r_state;
  logic r_dc_v, r_dc_w, r_dc_h, r_ic_v, r_ic_h;
  logic r_done, r_late, r_ovf;
  logic [CNT_W-1:0] r_cnt [9];
  logic [8:0] w_inc, w_sat;
  logic w_cap, w_ev;
  assign w_cap = r_state == COUNT;
  assign w_ev  = bus.dc_ev_valid | bus.ic_ev_valid | bus.trace_end;
  // index order: dc read total/hit/miss, dc write total/hit/miss, ic total/hit/miss
  assign w_inc = {r_ic_v & ~r_ic_h, r_ic_v & r_ic_h, r_ic_v,
                  r_dc_v & r_dc_w & ~r_dc_h, r_dc_v & r_dc_w & r_dc_h, r_dc_v & r_dc_w,
                  r_dc_v & ~r_dc_w & ~r_dc_h, r_dc_v & ~r_dc_w & r_dc_h, r_dc_v & ~r_dc_w};
  for (genvar i = 0; i < 9; i++) begin : g_sat
    assign w_sat[i] = &r_cnt[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COUNT;
      {r_dc_v, r_dc_w, r_dc_h, r_ic_v, r_ic_h} <= '0;
      {r_done, r_late, r_ovf} <= '0;
      r_cnt <= '{default: '0};
    end else if (bus.clear) begin
      r_state <= COUNT;
      {r_dc_v, r_dc_w, r_dc_h, r_ic_v, r_ic_h} <= '0;
      {r_done, r_late, r_ovf} <= '0;
      r_cnt <= '{default: '0};
    end else begin
      r_dc_v <= w_cap & bus.dc_ev_valid;
      r_dc_w <= bus.dc_ev_write;
      r_dc_h <= bus.dc_ev_hit;
      r_ic_v <= w_cap & bus.ic_ev_valid;
      r_ic_h <= bus.ic_ev_hit;
      for (int j = 0; j < 9; j++)
        if (w_inc[j] && !w_sat[j]) r_cnt[j] <= r_cnt[j] + CNT_W'(1);
      r_ovf   <= r_ovf | |(w_inc & w_sat);
      r_late  <= r_late | (!w_cap & w_ev);
      r_state <= w_cap ? (bus.trace_end ? DRAIN : COUNT) : DONE;
      r_done  <= !w_cap;
    end
  end
  assign bus.dc_reads      = r_cnt[0];
  assign bus.dc_read_hit   = r_cnt[1];
  assign bus.dc_read_miss  = r_cnt[2];
  assign bus.dc_writes     = r_cnt[3];
  assign bus.dc_write_hit  = r_cnt[4];
  assign bus.dc_write_miss = r_cnt[5];
  assign bus.ic_reads      = r_cnt[6];
  assign bus.ic_read_hit   = r_cnt[7];
  assign bus.ic_read_miss  = r_cnt[8];
  assign bus.done          = r_done;
  assign bus.late_event    = r_late;
  assign bus.overflow      = r_ovf;
endmodule

// File: tb/tb_cache_stats_controller.sv
// tb_cache_stats_controller: vector table with a 2-cycle-delayed scoreboard, plus corner sequences
module tb_cache_stats_controller;
  logic clk, rst;
  int checks = 0, failures = 0;
  cache_stats_if #(.CNT_W(32)) a ();
  cache_stats_if #(.CNT_W(4))  b ();
  cache_stats_controller #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(a));
  cache_stats_controller #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(b));

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct packed {logic dcv, dcw, dch, icv, ich, te, edone, elate;} vec_t;
  typedef logic [8:0][31:0] snap_t;
  vec_t tbl [18];
  snap_t q [$];
  snap_t m, act, e;
  logic m_end;
  string nm [9] = '{"dc_reads", "dc_read_hit", "dc_read_miss", "dc_writes", "dc_write_hit",
                    "dc_write_miss", "ic_reads", "ic_read_hit", "ic_read_miss"};

  task automatic chk(input string n, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", n, act_v, exp_v);
    end
  endtask

  function automatic snap_t rd();
    return {a.ic_read_miss, a.ic_read_hit, a.ic_reads, a.dc_write_miss, a.dc_write_hit,
            a.dc_writes, a.dc_read_miss, a.dc_read_hit, a.dc_reads};
  endfunction

  task automatic drive(input logic dcv, dcw, dch, icv, ich, te, clr);
    a.dc_ev_valid = dcv; a.dc_ev_write = dcw; a.dc_ev_hit = dch;
    a.ic_ev_valid = icv; a.ic_ev_hit = ich; a.trace_end = te; a.clear = clr;
  endtask

  task automatic model(input logic dcv, dcw, dch, icv, ich, te);
    if (!m_end) begin
      if (dcv && !dcw) begin m[0]++; if (dch) m[1]++; else m[2]++; end
      if (dcv && dcw)  begin m[3]++; if (dch) m[4]++; else m[5]++; end
      if (icv)         begin m[6]++; if (ich) m[7]++; else m[8]++; end
    end
    if (te) m_end = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input snap_t exp_s);
    act = rd();
    for (int k = 0; k < 9; k++) chk({tag, ".", nm[k]}, act[k], exp_s[k]);
  endtask

  initial begin
    //         dcv dcw dch icv ich te done late
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 0};
    tbl[16] = '{1, 0, 1, 0, 0, 0, 1, 1};
    tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 1};
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    {b.clear, b.trace_end, b.dc_ev_valid, b.dc_ev_write, b.dc_ev_hit, b.ic_ev_valid, b.ic_ev_hit} = '0;
    m = '0; m_end = 0;
    #12 rst = 0;
    step();
    chk_all("reset", '0);
    chk("reset.done", a.done, 0);
    chk("reset.late", a.late_event, 0);
    chk("reset.ovf", a.overflow, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].dcv, tbl[i].dcw, tbl[i].dch, tbl[i].icv, tbl[i].ich, tbl[i].te, 0);
      model(tbl[i].dcv, tbl[i].dcw, tbl[i].dch, tbl[i].icv, tbl[i].ich, tbl[i].te);
      q.push_back(m);
      step();
      if (q.size() >= 2) begin
        e = q.pop_front();
        chk_all($sformatf("vec%0d", i), e);
      end
      chk($sformatf("vec%0d.done", i), a.done, tbl[i].edone);
      chk($sformatf("vec%0d.late", i), a.late_event, tbl[i].elate);
    end
    q.delete();
    drive(0, 0, 0, 0, 0, 0, 0);
    e = {32'd1, 32'd5, 32'd6, 32'd4, 32'd1, 32'd5, 32'd2, 32'd3, 32'd5};
    chk_all("mixed", e);
    chk("mixed.ovf", a.overflow, 0);

    #3 rst = 1;
    #1;
    chk_all("async_rst", '0);
    chk("async_rst.done", a.done, 0);
    chk("async_rst.late", a.late_event, 0);
    @(negedge clk) rst = 0;
    step();

    drive(1, 1, 0, 0, 0, 1, 0);
    step();
    chk("simul.done_t", a.done, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("simul.done", a.done, 1);
    chk("simul.dc_write_miss", a.dc_write_miss, 1);
    chk("simul.dc_writes", a.dc_writes, 1);
    chk("simul.dc_reads", a.dc_reads, 0);
    chk("simul.late", a.late_event, 0);

    drive(0, 0, 0, 1, 1, 1, 1);
    step();
    chk_all("clear", '0);
    chk("clear.done", a.done, 0);
    chk("clear.late", a.late_event, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("clear.ic_reads", a.ic_reads, 1);
    chk("clear.ic_read_hit", a.ic_read_hit, 1);
    step();
    step();
    chk("clear.done_after", a.done, 0);

    b.ic_ev_valid = 1; b.ic_ev_hit = 1;
    for (int i = 0; i < 17; i++) step();
    b.ic_ev_valid = 0; b.ic_ev_hit = 0;
    step();
    step();
    chk("sat.ic_reads", 32'(b.ic_reads), 15);
    chk("sat.ic_read_hit", 32'(b.ic_read_hit), 15);
    chk("sat.ic_read_miss", 32'(b.ic_read_miss), 0);
    chk("sat.overflow", b.overflow, 1);
    chk("sat.main_ovf", a.overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
